rf_port_arbiter: RTL and testbench



---
 rtl/rf_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_rf_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_port_arbiter.sv
// Two-client front end for a 2R/1W register file: dedicated read ports per client,
// round-robin sharing of the write port, and an optional zeroing sweep after reset.
module rf_port_arbiter #(
  parameter logic CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_valid,
  input  logic        c0_we,
  input  logic [4:0]  c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic        c1_valid,
  input  logic        c1_we,
  input  logic [4:0]  c1_addr,
  input  logic [31:0] c1_wdata,
  output logic        c0_ready,
  output logic        c1_ready,
  output logic        c0_rvalid,
  output logic        c1_rvalid,
  output logic [31:0] c0_rdata,
  output logic [31:0] c1_rdata,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  output logic        busy
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_clr_cnt;
  logic        r_prio;
  logic        r_c0_rvalid;
  logic        r_c1_rvalid;
  logic [31:0] r_c0_rdata;
  logic [31:0] r_c1_rdata;

  logic w_run;
  logic w_c0_wr;
  logic w_c1_wr;
  logic w_conflict;
  logic w_c0_wacc;
  logic w_c1_wacc;
  logic w_c0_racc;
  logic w_c1_racc;
  logic w_c0_bypass;
  logic w_c1_bypass;

  assign w_run       = (r_state == S_RUN);
  assign w_c0_wr     = c0_valid & c0_we;
  assign w_c1_wr     = c1_valid & c1_we;
  assign w_conflict  = w_c0_wr & w_c1_wr;
  assign w_c0_wacc   = w_c0_wr & c0_ready;
  assign w_c1_wacc   = w_c1_wr & c1_ready;
  assign w_c0_racc   = c0_valid & ~c0_we & c0_ready;
  assign w_c1_racc   = c1_valid & ~c1_we & c1_ready;
  // A read racing the other client's write to the same address returns the new value.
  assign w_c0_bypass = w_c1_wacc & (c1_addr == c0_addr);
  assign w_c1_bypass = w_c0_wacc & (c0_addr == c1_addr);

  assign rf_ra1    = c0_addr;
  assign rf_ra2    = c1_addr;
  assign busy      = (r_state == S_CLEAR);
  assign c0_rvalid = r_c0_rvalid;
  assign c1_rvalid = r_c1_rvalid;
  assign c0_rdata  = r_c0_rdata;
  assign c1_rdata  = r_c1_rdata;

  // State register and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_clr_cnt <= 5'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= (r_state == S_CLEAR) ? (r_clr_cnt + 5'd1) : 5'd0;
    end
  end

  // Next state and handshake readiness
  always_comb begin
    w_state_nxt = r_state;
    c0_ready    = 1'b0;
    c1_ready    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == 5'd31) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
        if (w_conflict) begin
          c0_ready = ~r_prio;
          c1_ready = r_prio;
        end else begin
          c0_ready = 1'b1;
          c1_ready = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Write port mux: sweep, accepted client write, or idle
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (r_state == S_CLEAR) begin
      rf_we = 1'b1;
      rf_wa = r_clr_cnt;
    end else if (w_c0_wacc) begin
      rf_we = 1'b1;
      rf_wa = c0_addr;
      rf_wd = c0_wdata;
    end else if (w_c1_wacc) begin
      rf_we = 1'b1;
      rf_wa = c1_addr;
      rf_wd = c1_wdata;
    end else begin
      rf_we = 1'b0;
    end
  end

  // Priority pointer and registered read responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_c0_rvalid <= 1'b0;
      r_c1_rvalid <= 1'b0;
      r_c0_rdata  <= 32'd0;
      r_c1_rdata  <= 32'd0;
    end else begin
      // Loser of a write-write conflict gets priority next time.
      if (w_run && w_conflict) begin
        r_prio <= ~r_prio;
      end
      r_c0_rvalid <= w_c0_racc;
      r_c1_rvalid <= w_c1_racc;
      if (w_c0_racc) begin
        r_c0_rdata <= w_c0_bypass ? c1_wdata : rf_rd1;
      end
      if (w_c1_racc) begin
        r_c1_rdata <= w_c1_bypass ? c0_wdata : rf_rd2;
      end
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural 32x32 register file attached.
module tb_rf_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_valid, c0_we, c1_valid, c1_we;
  logic [4:0]  c0_addr, c1_addr;
  logic [31:0] c0_wdata, c1_wdata;
  logic        c0_ready, c1_ready, c0_rvalid, c1_rvalid;
  logic [31:0] c0_rdata, c1_rdata;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_we, busy;

  logic [31:0] mem [32] = '{default: 32'hA5A5_5A5A};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rf_rd1 = mem[rf_ra1];
  assign rf_rd2 = mem[rf_ra2];

  always @(posedge clk) begin
    if (rf_we) mem[rf_wa] <= rf_wd;
  end

  rf_port_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c1_valid(c1_valid), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c0_ready(c0_ready), .c1_ready(c1_ready),
    .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [4:0] a1, input logic [31:0] d1);
    c0_valid = v0; c0_we = we0; c0_addr = a0; c0_wdata = d0;
    c1_valid = v1; c1_we = we1; c1_addr = a1; c1_wdata = d1;
    #1;
  endtask

  task automatic check_sweep(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      check_eq("clr_busy", {31'd0, busy}, 32'd1);
      check_eq("clr_c0_ready", {31'd0, c0_ready}, 32'd0);
      check_eq("clr_c1_ready", {31'd0, c1_ready}, 32'd0);
      check_eq("clr_we", {31'd0, rf_we}, 32'd1);
      check_eq("clr_wa", {27'd0, rf_wa}, i);
      check_eq("clr_wd", rf_wd, 32'd0);
      next_cycle();
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    rst = 1'b0;
    // Requests during the sweep must be held off.
    drive(1'b1, 1'b0, 5'd7, 32'd0, 1'b1, 1'b1, 5'd2, 32'h1111_1111);
    check_eq("rst_c0_rvalid", {31'd0, c0_rvalid}, 32'd0);
    check_eq("rst_c1_rdata", c1_rdata, 32'd0);
    check_sweep(0, 31);

    drive(1'b1, 1'b0, 5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("run_busy", {31'd0, busy}, 32'd0);
    check_eq("run_c0_ready", {31'd0, c0_ready}, 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0003, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("r7_rvalid", {31'd0, c0_rvalid}, 32'd1);
    check_eq("r7_rdata", c0_rdata, 32'd0);
    check_eq("w3_ready", {31'd0, c0_ready}, 32'd1);
    check_eq("w3_we", {31'd0, rf_we}, 32'd1);
    check_eq("w3_wa", {27'd0, rf_wa}, 32'd3);
    check_eq("w3_wd", rf_wd, 32'h0000_0003);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 32'd0);
    check_eq("r3_ready", {31'd0, c1_ready}, 32'd1);
    check_eq("w3_c0_rvalid", {31'd0, c0_rvalid}, 32'd0);
    check_eq("idle_we", {31'd0, rf_we}, 32'd0);
    next_cycle();

    // Write-write conflict at prio 0: c0 first, then c1.
    drive(1'b1, 1'b1, 5'd4, 32'h4, 1'b1, 1'b1, 5'd5, 32'h5);
    check_eq("r3_rvalid", {31'd0, c1_rvalid}, 32'd1);
    check_eq("r3_rdata", c1_rdata, 32'h0000_0003);
    check_eq("cf1_c0_ready", {31'd0, c0_ready}, 32'd1);
    check_eq("cf1_c1_ready", {31'd0, c1_ready}, 32'd0);
    check_eq("cf1_wa", {27'd0, rf_wa}, 32'd4);
    check_eq("cf1_wd", rf_wd, 32'h4);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd5, 32'h5);
    check_eq("cf1b_c1_ready", {31'd0, c1_ready}, 32'd1);
    check_eq("cf1b_wa", {27'd0, rf_wa}, 32'd5);
    check_eq("r3_rvalid_drop", {31'd0, c1_rvalid}, 32'd0);
    check_eq("r3_rdata_hold", c1_rdata, 32'h0000_0003);
    next_cycle();
    drive(1'b1, 1'b1, 5'd6, 32'h6, 1'b1, 1'b1, 5'd8, 32'h8);
    check_eq("cf2_c0_ready", {31'd0, c0_ready}, 32'd0);
    check_eq("cf2_c1_ready", {31'd0, c1_ready}, 32'd1);
    check_eq("cf2_wd", rf_wd, 32'h8);
    next_cycle();
    drive(1'b1, 1'b1, 5'd6, 32'h6, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("cf2b_c0_ready", {31'd0, c0_ready}, 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 5'd10, 32'hA, 1'b1, 1'b1, 5'd11, 32'hB);
    check_eq("cf3_c0_ready", {31'd0, c0_ready}, 32'd1);
    check_eq("cf3_c1_ready", {31'd0, c1_ready}, 32'd0);
    next_cycle();

    // Read/write race on r9 returns the new value.
    drive(1'b1, 1'b0, 5'd9, 32'd0, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    check_eq("byp_c0_ready", {31'd0, c0_ready}, 32'd1);
    check_eq("byp_c1_ready", {31'd0, c1_ready}, 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("byp_rvalid", {31'd0, c0_rvalid}, 32'd1);
    check_eq("byp_rdata", c0_rdata, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b1, 1'b0, 5'd4, 32'd0, 1'b1, 1'b0, 5'd5, 32'd0);
    check_eq("r9_again", c0_rdata, 32'hDEAD_BEEF);
    check_eq("rr_c0_ready", {31'd0, c0_ready}, 32'd1);
    check_eq("rr_c1_ready", {31'd0, c1_ready}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("rr_c0_rvalid", {31'd0, c0_rvalid}, 32'd1);
    check_eq("rr_c1_rvalid", {31'd0, c1_rvalid}, 32'd1);
    check_eq("rr_c0_rdata", c0_rdata, 32'h4);
    check_eq("rr_c1_rdata", c1_rdata, 32'h5);

    // Reset mid-sweep restarts at address 0.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("rst2_rdata", c0_rdata, 32'd0);
    check_sweep(0, 10);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check_sweep(0, 31);

    // Sweep really zeroed r9, then reset right after an accepted read.
    drive(1'b1, 1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("run2_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("r9_cleared", c0_rdata, 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("pre_rst_rvalid", {31'd0, c0_rvalid}, 32'd1);
    check_eq("pre_rst_rdata", c0_rdata, 32'h33);
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("post_rst_rvalid", {31'd0, c0_rvalid}, 32'd0);
    check_eq("post_rst_rdata", c0_rdata, 32'd0);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
